lfsr_rand_gen: RTL and testbench
================================

# lfsr_rand_gen

Parametrised pseudo-random number generator: a WIDTH-bit Fibonacci LFSR with a configurable tap mask, runtime reseeding and all-zero lock-up recovery. A request/response front end returns values bounded to a caller-supplied inclusive limit, using masked rejection sampling with a bounded retry count. Game logic (obstacle placement, spawn timing) uses it as the shared randomness source.

## Interface
- WIDTH, 8, LFSR and value width (≥ 2)
- TAPS, 8'hB8, feedback mask; bit i set means state[i] feeds the XOR
- SEED, 8'h0F, reset/substitute state; must be non-zero
- MAX_TRIES, 4, rejection attempts before fallback (≥ 1)
- clock  in  1  system clock; all logic is on its rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  free-run advance of the LFSR when 1
- seed_load  in  1  load seed_in into the LFSR this cycle
- seed_in  in  WIDTH  new seed
- req_valid  in  1  request for a bounded value
- req_ready  out  1  high only in IDLE
- req_limit  in  WIDTH  inclusive upper bound; captured on request accept
- rnd_valid  out  1  result available
- rnd_ready  in  1  consumer accepts the result
- rnd_value  out  WIDTH  result, always ≤ the captured limit
- rnd_fallback  out  1  result came from the fallback path
- state_raw  out  WIDTH  current LFSR state
- lockup  out  1  one-cycle pulse when a zero state or zero seed is replaced

## Operation
- Next state: {state[WIDTH-2:0], ^(state & TAPS)}.
- State update priority: rst > seed_load > advance.
  - Advance happens when enable=1 or when the FSM is in DRAW.
  - seed_load with seed_in=0 loads SEED instead and pulses lockup.
  - A zero state reached any other way is replaced by SEED on the next edge, which also pulses lockup.
- On request accept (req_valid & req_ready):
  - Capture limit L.
  - Compute mask M = the smallest all-ones value ≥ L (L=0 gives M=0).
  - Clear the try counter.
- FSM states:
  - IDLE: req_ready=1. Go to DRAW on request accept.
  - DRAW: candidate C = state & M, using the pre-advance state of this cycle. The state advances regardless of enable.
    - If C ≤ L: latch rnd_value=C, set rnd_fallback=0, go to OUT.
    - Else increment tries. If tries reaches MAX_TRIES: latch rnd_value=C−(L+1), set rnd_fallback=1, go to OUT.
    - The fallback result is always ≤ L, because C ≤ M < 2(L+1).
  - OUT: rnd_valid=1. rnd_value and rnd_fallback hold until rnd_ready. Go to IDLE on rnd_ready.
- rnd_ready while not in OUT is ignored. A request is never accepted outside IDLE.
- seed_load during DRAW is legal: the next DRAW cycle samples the loaded value, and the try count is not reset.
- Reset values:
  - FSM state: IDLE.
  - state_raw: SEED.
  - req_ready: 1.
  - rnd_valid, rnd_value, rnd_fallback, lockup: 0.
  - Try counter: 0.
- Reset mid-operation abandons any request in flight; the result is never presented.

## Timing
- Request accepted at edge T → first DRAW in cycle T+1 → rnd_valid high from T+2 at the earliest.
- Worst case: rnd_valid high from T+1+MAX_TRIES.
- All outputs are registered. state_raw reflects the register, not the next-state value.
- After OUT is accepted at edge E, req_ready is high in cycle E+1. Back-to-back requests therefore cost at least 3 cycles each.
- lockup is high for exactly the one cycle following the replacing edge.
- Free-running sequence with WIDTH=8, TAPS=8'hB8, SEED=8'h0F: 0F, 1F, 3E, 7D, FB, …

## Test plan
- Reset, enable=1 for 4 cycles → state_raw shows 0F, 1F, 3E, 7D, FB; req_ready=1; rnd_valid=0; lockup=0.
- Reset, enable=0, request with L=8'hFF accepted at T → rnd_valid at T+2, rnd_value=0F, rnd_fallback=0; state_raw=1F.
- Reset, enable=0, request with L=9 → draws 0F, 0F, 0E, 0D are all rejected → rnd_value=03, rnd_fallback=1, rnd_valid at T+5.
- Request with L=0 → rnd_value=0 after a single DRAW. Hold rnd_ready=0 for 10 cycles → rnd_valid, rnd_value and rnd_fallback stay stable, and a req_valid pulse is not accepted.
- seed_load with seed_in=0 → state_raw=0F next cycle and lockup pulses once. seed_load with seed_in=8'hA5 → state_raw=A5, and the next state is 4A.
- rst asserted during DRAW and during OUT → the next cycle is IDLE with state_raw=0F, rnd_valid=0 and req_ready=1.

Source files
------------

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: Fibonacci LFSR random source with runtime reseeding,
// all-zero lock-up recovery and a request/response front end that returns
// values bounded to an inclusive limit via masked rejection sampling.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both high. req_ready is high only in IDLE;
// rnd_valid is high only in OUT, and rnd_value/rnd_fallback are held
// stable there until rnd_ready is seen. req_valid outside IDLE and
// rnd_ready outside OUT have no effect.
module lfsr_rand_gen #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   TAPS      = 8'hB8,
  parameter logic [WIDTH-1:0]   SEED      = 8'h0F,
  parameter int                 MAX_TRIES = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_limit,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [WIDTH-1:0] rnd_value,
  output logic             rnd_fallback,
  output logic [WIDTH-1:0] state_raw,
  output logic             lockup,
  output logic [1:0]       fsm_state
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_OUT  = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             fallback_q, fallback_d;
  logic             lockup_q, lockup_d;

  logic [WIDTH-1:0] mask_calc;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] candidate;
  logic [WIDTH-1:0] fallback_val;
  logic [TRY_W-1:0] tries_inc;

  assign lfsr_next    = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
  assign candidate    = lfsr_q & mask_q;
  // Only used when candidate > limit, so limit+1 cannot wrap here.
  assign fallback_val = candidate - (limit_q + WIDTH'(1));
  assign tries_inc    = tries_q + TRY_W'(1);

  // Smear the limit rightwards to get the smallest all-ones mask >= limit.
  always_comb begin
    mask_calc = req_limit;
    for (int i = 1; i < WIDTH; i = i * 2) begin
      mask_calc = mask_calc | (mask_calc >> i);
    end
  end

  // LFSR next state: reset handled in the register; seed_load beats advance,
  // and a zero seed or zero state is replaced by SEED with a lockup pulse.
  always_comb begin
    lfsr_d   = lfsr_q;
    lockup_d = 1'b0;
    if (seed_load) begin
      if (seed_in == '0) begin
        lfsr_d   = SEED;
        lockup_d = 1'b1;
      end else begin
        lfsr_d = seed_in;
      end
    end else if (lfsr_q == '0) begin
      lfsr_d   = SEED;
      lockup_d = 1'b1;
    end else if (enable || (fsm_q == S_DRAW)) begin
      lfsr_d = lfsr_next;
    end
  end

  // Request FSM: capture limit/mask, draw until accepted or out of tries,
  // then hold the result until the consumer takes it.
  always_comb begin
    fsm_d      = fsm_q;
    limit_d    = limit_q;
    mask_d     = mask_q;
    tries_d    = tries_q;
    value_d    = value_q;
    fallback_d = fallback_q;
    unique case (fsm_q)
      S_IDLE: begin
        if (req_valid) begin
          fsm_d   = S_DRAW;
          limit_d = req_limit;
          mask_d  = mask_calc;
          tries_d = '0;
        end
      end
      S_DRAW: begin
        if (candidate <= limit_q) begin
          value_d    = candidate;
          fallback_d = 1'b0;
          fsm_d      = S_OUT;
        end else begin
          tries_d = tries_inc;
          if (tries_inc == TRY_W'(MAX_TRIES)) begin
            value_d    = fallback_val;
            fallback_d = 1'b1;
            fsm_d      = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (rnd_ready) begin
          fsm_d = S_IDLE;
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      lfsr_q     <= SEED;
      limit_q    <= '0;
      mask_q     <= '0;
      tries_q    <= '0;
      value_q    <= '0;
      fallback_q <= 1'b0;
      lockup_q   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      limit_q    <= limit_d;
      mask_q     <= mask_d;
      tries_q    <= tries_d;
      value_q    <= value_d;
      fallback_q <= fallback_d;
      lockup_q   <= lockup_d;
    end
  end

  assign req_ready    = (fsm_q == S_IDLE);
  assign rnd_valid    = (fsm_q == S_OUT);
  assign rnd_value    = value_q;
  assign rnd_fallback = fallback_q;
  assign state_raw    = lfsr_q;
  assign lockup       = lockup_q;
  assign fsm_state    = fsm_q;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen (WIDTH=8, TAPS=B8, SEED=0F, MAX_TRIES=4).
module tb_lfsr_rand_gen;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         rst;
  logic         enable;
  logic         seed_load;
  logic [W-1:0] seed_in;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_limit;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [W-1:0] rnd_value;
  logic         rnd_fallback;
  logic [W-1:0] state_raw;
  logic         lockup;
  logic [1:0]   fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         en;
    logic         sl;
    logic [W-1:0] sin;
    logic [W-1:0] exp_state;
    logic         exp_lockup;
  } vec_t;

  vec_t vecs[10];

  lfsr_rand_gen #(
    .WIDTH(8), .TAPS(8'hB8), .SEED(8'h0F), .MAX_TRIES(4)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable), .seed_load(seed_load),
    .seed_in(seed_in), .req_valid(req_valid), .req_ready(req_ready),
    .req_limit(req_limit), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .rnd_value(rnd_value), .rnd_fallback(rnd_fallback),
    .state_raw(state_raw), .lockup(lockup), .fsm_state(fsm_state)
  );

  // Clock and reset block
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_in = '0;
    req_valid = 1'b0; req_limit = '0; rnd_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Driver: present one request for a single edge (caller ensures IDLE).
  task automatic send_req(input logic [W-1:0] lim);
    req_valid = 1'b1;
    req_limit = lim;
    step();
    req_valid = 1'b0;
  endtask

  // Count edges after accept until rnd_valid appears, bounded.
  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!rnd_valid && cycles < 20) begin
      step();
      cycles++;
    end
    if (!rnd_valid) check("rnd_valid timeout", 32'(rnd_valid), 32'd1);
  endtask

  // Scoreboard: compare held result against the oldest expected value.
  task automatic score(input string name, input logic exp_fb);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, " no expectation"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, " value"}, 32'(rnd_value), 32'(e));
      check({name, " fallback"}, 32'(rnd_fallback), 32'(exp_fb));
    end
  endtask

  task automatic consume();
    rnd_ready = 1'b1;
    step();
    rnd_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [W-1:0] held_val;

    vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h1F, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h00, 8'h3E, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 8'h7D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 8'h00, 8'hFB, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h0F, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h0F, 1'b0};
    vecs[6] = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h4A, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 8'h00, 8'h95, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 8'h00, 8'h95, 1'b0};

    // Reset values
    do_reset();
    check("reset state_raw", 32'(state_raw), 32'h0F);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rnd_valid", 32'(rnd_valid), 32'd0);
    check("reset lockup", 32'(lockup), 32'd0);
    check("reset rnd_value", 32'(rnd_value), 32'd0);
    check("reset rnd_fallback", 32'(rnd_fallback), 32'd0);

    // Free run, zero-seed recovery and reseeding, one edge per vector
    for (int i = 0; i < 10; i++) begin
      enable    = vecs[i].en;
      seed_load = vecs[i].sl;
      seed_in   = vecs[i].sin;
      step();
      check($sformatf("vec%0d state_raw", i), 32'(state_raw), 32'(vecs[i].exp_state));
      check($sformatf("vec%0d lockup", i), 32'(lockup), 32'(vecs[i].exp_lockup));
    end
    enable = 1'b0; seed_load = 1'b0; seed_in = '0;

    // L=FF: first draw 0F accepted, result two cycles after accept
    do_reset();
    exp_q.push_back(8'h0F);
    send_req(8'hFF);
    check("ff draw not yet valid", 32'(rnd_valid), 32'd0);
    wait_valid(cyc);
    check("ff latency", 32'(cyc), 32'd1);
    score("ff", 1'b0);
    check("ff state_raw", 32'(state_raw), 32'h1F);
    consume();
    check("ff req_ready after take", 32'(req_ready), 32'd1);
    check("ff rnd_valid after take", 32'(rnd_valid), 32'd0);

    // L=9: draws 0F,0F,0E,0D all rejected; fallback 0D-0A=03
    do_reset();
    exp_q.push_back(8'h03);
    send_req(8'd9);
    wait_valid(cyc);
    check("l9 latency", 32'(cyc), 32'd4);
    score("l9", 1'b1);
    check("l9 state_raw", 32'(state_raw), 32'hFB);
    consume();

    // L=0: single draw gives 0, then held with rnd_ready low
    do_reset();
    exp_q.push_back(8'h00);
    send_req(8'd0);
    wait_valid(cyc);
    check("l0 latency", 32'(cyc), 32'd1);
    held_val = rnd_value;
    score("l0", 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        req_valid = 1'b1;
        req_limit = 8'hFF;
      end
      check($sformatf("hold%0d req_ready", i), 32'(req_ready), 32'd0);
      step();
      req_valid = 1'b0;
      check($sformatf("hold%0d rnd_valid", i), 32'(rnd_valid), 32'd1);
      check($sformatf("hold%0d rnd_value", i), 32'(rnd_value), 32'h00);
      check($sformatf("hold%0d rnd_fallback", i), 32'(rnd_fallback), 32'd0);
      check($sformatf("hold%0d fsm_state", i), 32'(fsm_state), 32'd2);
    end
    consume();
    check("l0 back to idle", 32'(fsm_state), 32'd0);

    // Reset during DRAW abandons the request
    do_reset();
    send_req(8'd9);
    check("mid draw fsm", 32'(fsm_state), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst draw fsm", 32'(fsm_state), 32'd0);
    check("rst draw state_raw", 32'(state_raw), 32'h0F);
    check("rst draw rnd_valid", 32'(rnd_valid), 32'd0);
    check("rst draw req_ready", 32'(req_ready), 32'd1);
    step();
    step();
    check("rst draw stays idle", 32'(rnd_valid), 32'd0);

    // Reset during OUT drops the pending result
    do_reset();
    send_req(8'hFF);
    wait_valid(cyc);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst out fsm", 32'(fsm_state), 32'd0);
    check("rst out state_raw", 32'(state_raw), 32'h0F);
    check("rst out rnd_valid", 32'(rnd_valid), 32'd0);
    check("rst out req_ready", 32'(req_ready), 32'd1);
    check("rst out rnd_value", 32'(rnd_value), 32'd0);

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
